// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO multiply/divide unit for the execute stage.
//   MULT/MULTU complete in the issue cycle; DIV/DIVU run a radix-2 restoring
//   divider (issue + WIDTH RUN cycles stalled, then one DONE cycle that
//   commits the quotient to LO and remainder to HI).
//   Optional feature macro: HILO_DIV_ZERO_TRAP_EN -- trap divide-by-zero
//   instead of running it, and expose the div_zero pulse output.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       alucontrolE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             validE,
    input  logic             flushE,
    output logic             stall_req,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef HILO_DIV_ZERO_TRAP_EN
    ,
    output logic             div_zero
`endif
);

    // ALU control codes (SIG_ALU_* values shared with the decoder)
    localparam logic [4:0] SIG_ALU_MULT  = 5'h10;
    localparam logic [4:0] SIG_ALU_MULTU = 5'h11;
    localparam logic [4:0] SIG_ALU_DIV   = 5'h12;
    localparam logic [4:0] SIG_ALU_DIVU  = 5'h13;
    localparam logic [4:0] SIG_ALU_MFHI  = 5'h14;
    localparam logic [4:0] SIG_ALU_MFLO  = 5'h15;

    // Divider FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [CW-1:0]      cnt;

    logic               op_mult;
    logic               op_multu;
    logic               op_div;
    logic               op_divu;
    logic               issue_ok;
    logic               mul_issue;
    logic               div_issue;
    logic               div_start;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               neg_quot;
    logic               neg_rem;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

`ifdef HILO_DIV_ZERO_TRAP_EN
    logic               div_by_zero;
`endif

    // Opcode decode and issue qualification
    always_comb begin
        op_mult   = (alucontrolE == SIG_ALU_MULT);
        op_multu  = (alucontrolE == SIG_ALU_MULTU);
        op_div    = (alucontrolE == SIG_ALU_DIV);
        op_divu   = (alucontrolE == SIG_ALU_DIVU);
        issue_ok  = validE && !flushE && (state == IDLE);
        mul_issue = issue_ok && (op_mult || op_multu);
        div_issue = issue_ok && (op_div || op_divu);
`ifdef HILO_DIV_ZERO_TRAP_EN
        div_by_zero = (srcbE == '0);
        div_start   = div_issue && !div_by_zero;
`else
        div_start   = div_issue;
`endif
    end

    // Stall while a divide is being issued or iterating; forced low in reset
    always_comb begin
        stall_req = !rst && (((state == IDLE) && div_start) || (state == RUN));
    end

    // Full-width product; operands extended by signedness of the opcode
    always_comb begin
        ext_a   = op_mult ? {{WIDTH{srcaE[WIDTH-1]}}, srcaE} : {{WIDTH{1'b0}}, srcaE};
        ext_b   = op_mult ? {{WIDTH{srcbE[WIDTH-1]}}, srcbE} : {{WIDTH{1'b0}}, srcbE};
        product = ext_a * ext_b;
    end

    // Operand magnitudes for the divider (only DIV is signed)
    always_comb begin
        a_abs = (op_div && srcaE[WIDTH-1]) ? -srcaE : srcaE;
        b_abs = (op_div && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
    end

    // Sign correction of the final quotient and remainder
    always_comb begin
        quot_fix = neg_quot ? -quot : quot;
        rem_fix  = neg_rem  ? -rem  : rem;
    end

    // Divider next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (div_start) state_next = RUN;
            RUN: begin
                if (flushE)
                    state_next = IDLE;
                else if (cnt == CNT_LAST)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divider state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Divider datapath: latch magnitudes and signs at issue, iterate in RUN.
    // quot doubles as the dividend shift register: dividend bits leave at the
    // top while quotient bits enter at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_start) begin
                        cnt      <= '0;
                        quot     <= a_abs;
                        rem      <= '0;
                        divisor  <= b_abs;
                        neg_quot <= op_div && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        neg_rem  <= op_div && srcaE[WIDTH-1];
                    end
                end
                RUN: begin
                    if (flushE) begin
                        cnt <= '0;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        quot <= {quot[WIDTH-2:0], ~diff[WIDTH]};
                        rem  <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // HI/LO: multiply writes at issue, divide commits in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (mul_issue) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
        end else if (state == DONE) begin
            hi <= rem_fix;
            lo <= quot_fix;
        end
    end

`ifdef HILO_DIV_ZERO_TRAP_EN
    // One-cycle pulse following a trapped divide-by-zero issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_zero <= 1'b0;
        else
            div_zero <= div_issue && div_by_zero;
    end
`endif

    // MFHI/MFLO read port
    always_comb begin
        case (alucontrolE)
            SIG_ALU_MFHI: result = hi;
            SIG_ALU_MFLO: result = lo;
            default:      result = '0;
        endcase
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv (WIDTH=32), reference model uses plain
// SystemVerilog arithmetic. Build with HILO_DIV_ZERO_TRAP_EN to cover the trap.
module tb_hilo_muldiv;

    localparam logic [4:0] NOP   = 5'h00;
    localparam logic [4:0] MULT  = 5'h10;
    localparam logic [4:0] MULTU = 5'h11;
    localparam logic [4:0] DIV   = 5'h12;
    localparam logic [4:0] DIVU  = 5'h13;
    localparam logic [4:0] MFHI  = 5'h14;
    localparam logic [4:0] MFLO  = 5'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alucontrolE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        validE;
    logic        flushE;
    logic        stall_req;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef HILO_DIV_ZERO_TRAP_EN
    logic        div_zero;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .alucontrolE(alucontrolE),
        .srcaE(srcaE),
        .srcbE(srcbE),
        .validE(validE),
        .flushE(flushE),
        .stall_req(stall_req),
        .result(result),
        .hi(hi),
        .lo(lo)
`ifdef HILO_DIV_ZERO_TRAP_EN
        ,
        .div_zero(div_zero)
`endif
    );

    // Reference: full 64-bit product
    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] pu;
        if (sgn) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p;
        end
        pu = {32'b0, a} * {32'b0, b};
        return pu;
    endfunction

    // Reference: {hi=remainder, lo=quotient} with MIPS-style sign rules
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] qh, rh;
        if (b == 0) begin
            qh = (sgn && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
            rh = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            qh = q[31:0];
            rh = r[31:0];
        end else begin
            qh = a / b;
            rh = a % b;
        end
        return {rh, qh};
    endfunction

    task automatic drive_idle();
        validE      = 1'b0;
        flushE      = 1'b0;
        alucontrolE = NOP;
        srcaE       = '0;
        srcbE       = '0;
    endtask

    task automatic do_mult(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        validE = 1'b1; flushE = 1'b0; alucontrolE = op; srcaE = a; srcbE = b;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL mul_stall got=%b exp=0", stall_req); end
        {m_hi, m_lo} = ref_mul(op == MULT, a, b);
        @(posedge clk); #1;
        alucontrolE = MFHI; srcaE = $urandom; srcbE = $urandom;
        @(negedge clk);
        total++;
        if (hi !== m_hi) begin bad++; $display("FAIL mul_hi a=%h b=%h got=%h exp=%h", a, b, hi, m_hi); end
        total++;
        if (lo !== m_lo) begin bad++; $display("FAIL mul_lo a=%h b=%h got=%h exp=%h", a, b, lo, m_lo); end
        total++;
        if (result !== m_hi) begin bad++; $display("FAIL mul_mfhi got=%h exp=%h", result, m_hi); end
        drive_idle();
    endtask

    task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        @(posedge clk); #1;
        validE = 1'b1; flushE = 1'b0; alucontrolE = op; srcaE = a; srcbE = b;
        cnt = 0;
        // Instruction stays in E while stalled; re-issue attempts must be ignored
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_req === 1'b1) cnt++;
            else break;
        end
        {m_hi, m_lo} = ref_div(op == DIV, a, b);
        total++;
        if (cnt != 33) begin bad++; $display("FAIL div_stall_cycles a=%h b=%h got=%0d exp=33", a, b, cnt); end
        @(posedge clk); #1;
        alucontrolE = MFLO; srcaE = $urandom; srcbE = $urandom;
        @(negedge clk);
        total++;
        if (lo !== m_lo) begin bad++; $display("FAIL div_lo a=%h b=%h got=%h exp=%h", a, b, lo, m_lo); end
        total++;
        if (hi !== m_hi) begin bad++; $display("FAIL div_hi a=%h b=%h got=%h exp=%h", a, b, hi, m_hi); end
        total++;
        if (result !== m_lo) begin bad++; $display("FAIL div_mflo got=%h exp=%h", result, m_lo); end
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL div_post_stall got=%b exp=0", stall_req); end
        @(posedge clk); #1;
        alucontrolE = MFHI;
        @(negedge clk);
        total++;
        if (result !== m_hi) begin bad++; $display("FAIL div_mfhi got=%h exp=%h", result, m_hi); end
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        alucontrolE = MFLO;
        #3;
        total++;
        if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
        total++;
        if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        total++;
        if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_mult();
        do_mult(MULT,  32'hFFFF_FFFF, 32'h2);
        do_mult(MULTU, 32'hFFFF_FFFF, 32'h2);
        do_mult(MULT,  32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 10; i++)
            do_mult(($urandom_range(0, 1) == 0) ? MULT : MULTU, $urandom, $urandom);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic [4:0]  op;
        logic [63:0] prev;
        prev = '0;
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = (i % 2 == 0) ? MULT : MULTU;
            @(posedge clk); #1;
            validE = 1'b1; alucontrolE = op; srcaE = a; srcbE = b;
            @(negedge clk);
            total++;
            if (stall_req !== 1'b0) begin bad++; $display("FAIL b2b_stall got=%b exp=0", stall_req); end
            if (i > 0) begin
                total++;
                if ({hi, lo} !== prev) begin bad++; $display("FAIL b2b_hilo got=%h exp=%h", {hi, lo}, prev); end
            end
            prev = ref_mul(op == MULT, a, b);
        end
        @(posedge clk); #1;
        alucontrolE = MFLO;
        @(negedge clk);
        {m_hi, m_lo} = prev;
        total++;
        if (result !== m_lo) begin bad++; $display("FAIL b2b_mflo got=%h exp=%h", result, m_lo); end
        drive_idle();
    endtask

    task automatic test_div();
        logic [31:0] a, b;
        do_div(DIVU, 32'd100, 32'd7);
        do_div(DIV,  32'hFFFF_FFF9, 32'h2);
        do_div(DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        do_div(DIV,  32'h0000_0007, 32'hFFFF_FFFE);
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 20) : $urandom;
            if ($urandom_range(0, 3) == 0) b = -b;
            if (b == 0) b = 32'd3;
            do_div(($urandom_range(0, 1) == 0) ? DIV : DIVU, a, b);
        end
    endtask

    task automatic test_flush_run();
        do_mult(MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        validE = 1'b1; alucontrolE = DIVU; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b1) begin bad++; $display("FAIL flush_run_before got=%b exp=1", stall_req); end
        @(posedge clk); #1;
        flushE = 1'b0;
        alucontrolE = MFLO;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (stall_req !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
                bad++;
                $display("FAIL flush_run_after cyc=%0d stall=%b hi=%h lo=%h exp 0 %h %h", i, stall_req, hi, lo, m_hi, m_lo);
                break;
            end
        end
        drive_idle();
        do_div(DIVU, 32'd100, 32'd7);
    endtask

    task automatic test_flush_issue();
        do_mult(MULT, 32'hFFFF_0001, 32'h0000_0123);
        @(posedge clk); #1;
        validE = 1'b1; flushE = 1'b1; alucontrolE = DIVU; srcaE = 32'd100; srcbE = 32'd7;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_issue_div_stall got=%b exp=0", stall_req); end
        @(posedge clk); #1;
        alucontrolE = MULTU; srcaE = $urandom; srcbE = $urandom;
        @(posedge clk); #1;
        drive_idle();
        alucontrolE = MFHI;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL flush_issue_state stall=%b hi=%h lo=%h exp 0 %h %h", stall_req, hi, lo, m_hi, m_lo);
        end
        drive_idle();
    endtask

    task automatic test_reset_run();
        do_mult(MULTU, 32'hDEAD_BEEF, 32'h0000_0011);
        @(posedge clk); #1;
        validE = 1'b1; alucontrolE = DIVU; srcaE = 32'd100; srcbE = 32'd7;
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_hi = '0; m_lo = '0;
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_run_stall got=%b exp=0", stall_req); end
        total++;
        if (hi !== m_hi || lo !== m_lo) begin bad++; $display("FAIL rst_run_hilo got=%h_%h exp=0", hi, lo); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_run_after got=%b exp=0", stall_req); end
        do_div(DIV, 32'hFFFF_FF9C, 32'd7);
    endtask

    task automatic test_div_zero();
`ifdef HILO_DIV_ZERO_TRAP_EN
        do_mult(MULTU, 32'h0BAD_F00D, 32'h0000_0101);
        @(posedge clk); #1;
        validE = 1'b1; alucontrolE = DIVU; srcaE = 32'd5; srcbE = 32'd0;
        @(negedge clk);
        total++;
        if (stall_req !== 1'b0 || div_zero !== 1'b0) begin
            bad++; $display("FAIL trap_issue stall=%b dz=%b exp 0 0", stall_req, div_zero);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        total++;
        if (div_zero !== 1'b1 || stall_req !== 1'b0) begin
            bad++; $display("FAIL trap_pulse dz=%b stall=%b exp 1 0", div_zero, stall_req);
        end
        @(negedge clk);
        total++;
        if (div_zero !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            bad++; $display("FAIL trap_after dz=%b hi=%h lo=%h exp 0 %h %h", div_zero, hi, lo, m_hi, m_lo);
        end
        do_div(DIVU, 32'd9, 32'd2);
`else
        do_div(DIVU, 32'd5, 32'd0);
        do_div(DIV,  32'hFFFF_FFF9, 32'd0);
        do_div(DIV,  32'd12, 32'd0);
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_flush_run();
        test_flush_issue();
        test_reset_run();
        test_div_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width and the width of each of HI and LO.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port alucontrolE, input, 5 bits: execute-stage ALU code (SIG_ALU_* from define_alu_ctrl.vh).
REQ-005 SHALL have port srcaE, input, WIDTH bits: dividend or multiplicand (rs).
REQ-006 SHALL have port srcbE, input, WIDTH bits: divisor or multiplier (rt).
REQ-007 SHALL have port validE, input, 1 bit: the execute-stage instruction is live.
REQ-008 SHALL have port flushE, input, 1 bit: cancel the current execute instruction.
REQ-009 SHALL have port stall_req, output, 1 bit: holds the pipeline while a divide is in progress.
REQ-010 SHALL have port result, output, WIDTH bits: hi for SIG_ALU_MFHI, lo for SIG_ALU_MFLO, 0 otherwise.
REQ-011 SHALL have port hi, output, WIDTH bits: the HI register.
REQ-012 SHALL have port lo, output, WIDTH bits: the LO register.
REQ-013 SHALL have port div_zero, output, 1 bit: divide-by-zero pulse (present only with the REQ-030 macro).

Function
REQ-014 Issue SHALL mean validE=1, flushE=0, state IDLE, and alucontrolE one of MULT, MULTU, DIV, DIVU.
REQ-015 A MULT/MULTU issue SHALL write the full 2*WIDTH product: high half to hi, low half to lo, at the issue-cycle edge.
REQ-016 MULT SHALL treat operands as two's complement; MULTU SHALL treat them as unsigned.
REQ-017 A multiply SHALL keep stall_req=0.
REQ-018 The state machine SHALL have states IDLE, RUN and DONE.
REQ-019 Transitions SHALL be: IDLE->RUN on a DIV/DIVU issue; RUN->DONE after 32 iterations; DONE->IDLE unconditionally.
REQ-020 stall_req SHALL be combinational: 1 during a DIV/DIVU issue cycle in IDLE, and 1 throughout RUN; 0 in DONE and otherwise.
REQ-021 The first stall_req=1 cycle SHALL be the issue cycle, followed by exactly 32 RUN cycles, followed by one DONE cycle (33 stall cycles in total).
REQ-022 Division SHALL be radix-2 restoring on absolute operand values latched at issue; a 5-bit counter SHALL count 0..31.
REQ-023 DIV sign rules SHALL be: quotient negated if operand signs differ; remainder takes the sign of the dividend.
REQ-024 0x80000000 DIV 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-025 At the DONE-cycle edge, lo SHALL be written with the quotient and hi with the remainder; an MFHI/MFLO in the following cycle sees the new values.
REQ-026 flushE=1 in RUN SHALL abort: next state IDLE, stall_req=0 in the following cycle, hi and lo unchanged.
REQ-027 flushE=1 on an issue cycle SHALL suppress the issue.
REQ-028 Issue attempts while in RUN or DONE SHALL be ignored; the pipeline is stalled in those states anyway.

Reset
REQ-029 rst=1 SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, stall_req=0, div_zero=0; a divide in progress is discarded.

Configuration
REQ-030 With macro HILO_DIV_ZERO_TRAP_EN defined, a DIV/DIVU issue with srcbE=0 SHALL not enter RUN, SHALL keep stall_req=0, SHALL leave hi and lo unchanged, and SHALL pulse div_zero=1 for exactly one cycle.
REQ-031 With HILO_DIV_ZERO_TRAP_EN undefined, divide-by-zero SHALL run the full 33 cycles and the div_zero port SHALL be absent.
REQ-032 Without the macro, a divide-by-zero SHALL produce lo=0xFFFFFFFF (DIVU, or DIV with non-negative dividend) or lo=0x00000001 (DIV with negative dividend), and hi=dividend.

Verification
REQ-033 MULT 0xFFFFFFFF,0x2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x1, lo=0xFFFFFFFE; stall_req stays 0 throughout.
REQ-034 DIVU 100,7 -> stall_req high for exactly 33 cycles, then hi=2, lo=0xE; an MFLO on the next cycle gives result=0xE.
REQ-035 DIV 0xFFFFFFF9,2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000,0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 100,7 with flushE pulsed at RUN cycle 10 -> stall_req=0 on the next cycle, hi and lo retain their prior values.
REQ-037 rst asserted at RUN cycle 5 -> immediately state IDLE, hi=lo=0, stall_req=0.
REQ-038 DIVU 5,0: with the macro -> div_zero pulses once, no stall; without the macro -> 33 stall cycles, then lo=0xFFFFFFFF, hi=5.
